// File: rtl/letter_typewriter_pkg.sv
// Shared menu definitions: typewriter state encoding and letter-code constants
// used by the letter sequence source, the typewriter and the menu text drawer.
package letter_typewriter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TYPE,
        HOLD,
        DONE
    } tw_state_t;

    typedef logic [4:0] letter_code_t;

    localparam letter_code_t END_CODE   = 5'd31;
    localparam letter_code_t SPACE_CODE = 5'd0;

endpackage

// File: rtl/letter_typewriter_frame_divider.sv
// Counts startOfFrame ticks up to a loadable terminal value, emitting a
// terminal-count pulse on the tick that reaches it; clear forces the count to 0.
module letter_typewriter_frame_divider #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          resetN,
    input  logic          tick,
    input  logic          enable,
    input  logic          clear,
    input  logic [CW-1:0] limit,
    output logic          terminal
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          at_limit;

    // >= keeps the count bounded even if the limit is lowered mid-count
    assign at_limit = (count_reg >= limit);
    assign terminal = enable && tick && at_limit;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (enable && tick) begin
            count_next = at_limit ? '0 : count_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/letter_typewriter.sv
// Menu typewriter: snapshots a letter array on start and reveals one letter per
// FRAMES_PER_LETTER frames, then holds the full text for HOLD_FRAMES frames.
module letter_typewriter
    import letter_typewriter_pkg::*;
#(
    parameter int           NUM_LETTERS       = 16,
    parameter int           FRAMES_PER_LETTER = 8,
    parameter int           HOLD_FRAMES       = 120,
    parameter logic [4:0]   END_CODE          = letter_typewriter_pkg::END_CODE
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            startOfFrame,
    input  logic                            start,
    input  logic [NUM_LETTERS-1:0][4:0]     letters,
    output logic [NUM_LETTERS-1:0]          visible_mask,
    output logic [$clog2(NUM_LETTERS)-1:0]  cur_index,
    output logic [4:0]                      cur_letter,
    output logic                            letter_strobe,
    output logic                            busy,
    output logic                            done
);

    localparam int IW      = $clog2(NUM_LETTERS);
    localparam int MAX_FR  = (FRAMES_PER_LETTER > HOLD_FRAMES) ? FRAMES_PER_LETTER : HOLD_FRAMES;
    localparam int CW      = (MAX_FR > 1) ? $clog2(MAX_FR) : 1;
    localparam logic [CW-1:0] TYPE_LIMIT = CW'(FRAMES_PER_LETTER - 1);
    localparam logic [CW-1:0] HOLD_LIMIT = CW'(HOLD_FRAMES - 1);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_LETTERS - 1);

    tw_state_t              state_reg, state_next;
    logic [IW-1:0]          idx_reg, idx_next;
    logic [NUM_LETTERS-1:0] mask_reg, mask_next;
    logic [IW-1:0]          cur_index_reg, cur_index_next;
    letter_code_t           cur_letter_reg, cur_letter_next;
    logic                   strobe_reg, strobe_next;
    letter_code_t           snap_reg [NUM_LETTERS];
    letter_code_t           snap_cur;

    logic                   load_snap;
    logic                   div_enable;
    logic                   div_tc;
    logic [CW-1:0]          div_limit;

    assign busy       = (state_reg == TYPE) || (state_reg == HOLD);
    assign done       = (state_reg == DONE);
    assign div_enable = busy;
    assign div_limit  = (state_reg == HOLD) ? HOLD_LIMIT : TYPE_LIMIT;
    assign snap_cur   = snap_reg[idx_reg];

    letter_typewriter_frame_divider #(
        .CW (CW)
    ) u_frame_divider (
        .clk      (clk),
        .resetN   (resetN),
        .tick     (startOfFrame),
        .enable   (div_enable),
        .clear    (load_snap),
        .limit    (div_limit),
        .terminal (div_tc)
    );

    // Snapshot decouples the reveal from later edits of the source array
    for (genvar gi = 0; gi < NUM_LETTERS; gi++) begin : g_snap
        always_ff @(posedge clk) begin
            if (resetN) begin
                snap_reg[gi] <= SPACE_CODE;
            end else if (load_snap) begin
                snap_reg[gi] <= letters[gi];
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        mask_next       = mask_reg;
        cur_index_next  = cur_index_reg;
        cur_letter_next = cur_letter_reg;
        strobe_next     = 1'b0;
        load_snap       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    load_snap  = 1'b1;
                    mask_next  = '0;
                    idx_next   = '0;
                    state_next = TYPE;
                end
            end
            TYPE: begin
                if (div_tc) begin
                    if (snap_cur == END_CODE) begin
                        state_next = HOLD;
                    end else begin
                        mask_next[idx_reg] = 1'b1;
                        cur_letter_next    = snap_cur;
                        cur_index_next     = idx_reg;
                        strobe_next        = 1'b1;
                        if (idx_reg == LAST_IDX) begin
                            state_next = HOLD;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (div_tc) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            mask_reg       <= '0;
            cur_index_reg  <= '0;
            cur_letter_reg <= SPACE_CODE;
            strobe_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            idx_reg        <= idx_next;
            mask_reg       <= mask_next;
            cur_index_reg  <= cur_index_next;
            cur_letter_reg <= cur_letter_next;
            strobe_reg     <= strobe_next;
        end
    end

    assign visible_mask  = mask_reg;
    assign cur_index     = cur_index_reg;
    assign cur_letter    = cur_letter_reg;
    assign letter_strobe = strobe_reg;

endmodule

// File: tb/tb_letter_typewriter.sv
// Directed bench for letter_typewriter: default pacing instance (a) and a
// one-frame-per-letter, one-frame-hold instance (b).
module tb_letter_typewriter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_a, sof_a, start_a;
    logic [15:0][4:0] letters_a;
    logic [15:0]      a_mask;
    logic [3:0]       a_idx;
    logic [4:0]       a_letter;
    logic             a_strobe, a_busy, a_done;

    logic             rst_b, sof_b, start_b;
    logic [15:0][4:0] letters_b;
    logic [15:0]      b_mask;
    logic [3:0]       b_idx;
    logic [4:0]       b_letter;
    logic             b_strobe, b_busy, b_done;

    int tests = 0;
    int fails = 0;
    int a_strobes = 0;
    int base;

    letter_typewriter dut_a (
        .clk           (clk),
        .resetN        (rst_a),
        .startOfFrame  (sof_a),
        .start         (start_a),
        .letters       (letters_a),
        .visible_mask  (a_mask),
        .cur_index     (a_idx),
        .cur_letter    (a_letter),
        .letter_strobe (a_strobe),
        .busy          (a_busy),
        .done          (a_done)
    );

    letter_typewriter #(
        .FRAMES_PER_LETTER (1),
        .HOLD_FRAMES       (1)
    ) dut_b (
        .clk           (clk),
        .resetN        (rst_b),
        .startOfFrame  (sof_b),
        .start         (start_b),
        .letters       (letters_b),
        .visible_mask  (b_mask),
        .cur_index     (b_idx),
        .cur_letter    (b_letter),
        .letter_strobe (b_strobe),
        .busy          (b_busy),
        .done          (b_done)
    );

    always @(posedge clk) begin
        if (a_strobe) a_strobes <= a_strobes + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_a();
        sof_a = 1'b1;
        @(negedge clk);
        sof_a = 1'b0;
    endtask

    task automatic frames_a(input int n);
        repeat (n) begin
            pulse_a();
            repeat (9) @(negedge clk);
        end
    endtask

    task automatic start_pulse_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1; sof_a = 1'b0; start_a = 1'b0;
        rst_b = 1'b1; sof_b = 1'b0; start_b = 1'b0;
        for (int i = 0; i < 16; i++) begin
            letters_a[i] = 5'(i + 1);
            letters_b[i] = 5'(i + 1);
        end
        repeat (3) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // reset state
        check("rst_mask",   a_mask,   0);
        check("rst_idx",    a_idx,    0);
        check("rst_letter", a_letter, 0);
        check("rst_strobe", a_strobe, 0);
        check("rst_busy",   a_busy,   0);
        check("rst_done",   a_done,   0);
        check("rst_b_busy", b_busy,   0);

        // frames in IDLE do nothing
        base = a_strobes;
        frames_a(9);
        check("idle_sof_busy",    a_busy, 0);
        check("idle_sof_strobes", a_strobes - base, 0);

        // letters 1..16, full run
        base = a_strobes;
        start_pulse_a();
        check("t1_busy_after_start", a_busy, 1);
        check("t1_done_after_start", a_done, 0);
        frames_a(7);
        check("t1_no_strobe_before_8", a_strobes - base, 0);
        pulse_a();
        check("t1_first_strobe", a_strobe, 1);
        check("t1_first_letter", a_letter, 1);
        check("t1_first_mask",   a_mask,   16'h0001);
        check("t1_first_idx",    a_idx,    0);
        @(negedge clk);
        check("t1_strobe_drop",  a_strobe, 0);
        repeat (8) @(negedge clk);
        frames_a(15 * 8);
        check("t1_full_mask",    a_mask,   16'hFFFF);
        check("t1_last_letter",  a_letter, 16);
        check("t1_last_idx",     a_idx,    15);
        check("t1_strobe_count", a_strobes - base, 16);
        check("t1_busy_hold",    a_busy,   1);
        frames_a(119);
        check("t1_done_pre",     a_done,   0);
        frame_done_check: begin
            frames_a(1);
            check("t1_done",      a_done, 1);
            check("t1_busy_done", a_busy, 0);
        end
        frames_a(3);
        check("t1_done_mask_held", a_mask, 16'hFFFF);
        check("t1_done_level",     a_done, 1);

        // letters 5,0,7,END
        letters_a[0] = 5'd5; letters_a[1] = 5'd0; letters_a[2] = 5'd7; letters_a[3] = 5'd31;
        for (int i = 4; i < 16; i++) letters_a[i] = 5'd9;
        base = a_strobes;
        start_pulse_a();
        frames_a(8);
        check("t2_l0", a_letter, 5);
        check("t2_m0", a_mask,   16'h0001);
        frames_a(8);
        check("t2_l1_space", a_letter, 0);
        check("t2_m1",       a_mask,   16'h0003);
        check("t2_i1",       a_idx,    1);
        frames_a(8);
        check("t2_l2", a_letter, 7);
        check("t2_m2", a_mask,   16'h0007);
        frames_a(8);
        check("t2_end_no_strobe", a_strobes - base, 3);
        check("t2_end_mask",      a_mask, 16'h0007);
        check("t2_end_letter",    a_letter, 7);
        frames_a(119);
        check("t2_done_pre", a_done, 0);
        frames_a(1);
        check("t2_done", a_done, 1);

        // END_CODE at index 0
        letters_a[0] = 5'd31;
        base = a_strobes;
        start_pulse_a();
        frames_a(8);
        check("t3_no_strobe", a_strobes - base, 0);
        check("t3_mask",      a_mask, 0);
        check("t3_busy",      a_busy, 1);
        frames_a(119);
        check("t3_done_pre", a_done, 0);
        frames_a(1);
        check("t3_done", a_done, 1);

        // start and startOfFrame together from DONE: that frame is not counted
        for (int i = 0; i < 16; i++) letters_a[i] = 5'(i + 1);
        start_a = 1'b1; sof_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; sof_a = 1'b0;
        repeat (9) @(negedge clk);
        base = a_strobes;
        check("t4_restart_busy", a_busy, 1);
        frames_a(7);
        check("t4_no_early_strobe", a_strobes - base, 0);
        pulse_a();
        check("t4_strobe", a_strobe, 1);
        check("t4_letter", a_letter, 1);
        repeat (9) @(negedge clk);

        // mid-TYPE letter change and start are ignored
        for (int i = 0; i < 16; i++) letters_a[i] = 5'd9;
        start_pulse_a();
        repeat (8) @(negedge clk);
        frames_a(8);
        check("t5_letter", a_letter, 2);
        check("t5_idx",    a_idx,    1);
        check("t5_mask",   a_mask,   16'h0003);

        // reset mid-TYPE
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("t6_mask",   a_mask,   0);
        check("t6_letter", a_letter, 0);
        check("t6_idx",    a_idx,    0);
        check("t6_strobe", a_strobe, 0);
        check("t6_busy",   a_busy,   0);
        check("t6_done",   a_done,   0);
        frames_a(8);
        check("t6_idle_mask", a_mask, 0);
        check("t6_idle_busy", a_busy, 0);

        // one frame per letter, one-frame hold
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            sof_b = 1'b1;
            @(negedge clk);
            sof_b = 1'b0;
            check($sformatf("b_strobe_%0d", i), b_strobe, 1);
            check($sformatf("b_letter_%0d", i), b_letter, 32'(i + 1));
            repeat (2) @(negedge clk);
        end
        check("b_mask_full", b_mask, 16'hFFFF);
        check("b_done_pre",  b_done, 0);
        check("b_busy_pre",  b_busy, 1);
        sof_b = 1'b1;
        @(negedge clk);
        sof_b = 1'b0;
        check("b_done", b_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
